// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game-state sequencer with ring-buffer body
// and a registered 101-bit occupancy vector for the renderer.
module snake_ctrl #(
    parameter int GRID_W   = 10,
    parameter int GRID_H   = 10,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         tick,
    input  logic [1:0]   dir_in,
    input  logic         dir_valid,
    input  logic [6:0]   food_pos,
    output logic [100:0] regtar,
    output logic [6:0]   head_pos,
    output logic [4:0]   length,
    output logic         food_eaten,
    output logic         busy
);

    localparam int PW = $clog2(MAX_LEN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_DEAD   = 3'd5;

    localparam logic [99:0]   INIT_MAP = 100'b111 << 52;
    localparam logic [PW-1:0] P1       = PW'(1);

    logic [2:0]    state;
    logic [99:0]   bmap;
    logic          over;
    logic [6:0]    hd;
    logic [4:0]    len;
    logic          eat;
    logic [1:0]    cur_dir;
    logic [1:0]    pend_dir;
    logic [PW-1:0] hptr;
    logic [PW-1:0] tptr;
    logic [6:0]    ring [MAX_LEN];

    logic [6:0]    nh_r;
    logic          hit_r;
    logic          grow_r;
    logic          eat_r;

    logic [6:0]    tail_cell;
    logic [6:0]    hx;
    logic [6:0]    hy;
    logic [6:0]    nh;
    logic          wall;
    logic          grow;
    logic          on_body;
    logic          selfh;

    assign tail_cell = ring[tptr];
    assign hx = 7'(hd % 7'(GRID_W));
    assign hy = 7'(hd / 7'(GRID_W));
    assign busy = (state == S_INIT) || (state == S_STEP) ||
                  (state == S_COMMIT);

    // pend_dir is the direction that takes effect on this step
    always_comb begin
        nh   = hd;
        wall = 1'b0;
        unique case (pend_dir)
            2'd0: begin
                wall = (hy == 7'd0);
                nh   = hd - 7'(GRID_W);
            end
            2'd1: begin
                wall = (hx == 7'(GRID_W - 1));
                nh   = hd + 7'd1;
            end
            2'd2: begin
                wall = (hy == 7'(GRID_H - 1));
                nh   = hd + 7'(GRID_W);
            end
            2'd3: begin
                wall = (hx == 7'd0);
                nh   = hd - 7'd1;
            end
        endcase
        grow    = (nh == food_pos) && (len < 5'(MAX_LEN));
        on_body = (nh < 7'd100) ? bmap[nh] : 1'b0;
        selfh   = on_body && !((nh == tail_cell) && !grow);
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            ring[PW'(0)] <= 7'd52;
            ring[PW'(1)] <= 7'd53;
            ring[PW'(2)] <= 7'd54;
        end else if (state == S_COMMIT && !hit_r) begin
            ring[hptr + P1] <= nh_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bmap       <= '0;
            over       <= 1'b0;
            hd         <= '0;
            len        <= '0;
            eat        <= 1'b0;
            cur_dir    <= 2'd1;
            pend_dir   <= 2'd1;
            hptr       <= '0;
            tptr       <= '0;
            nh_r       <= '0;
            hit_r      <= 1'b0;
            grow_r     <= 1'b0;
            eat_r      <= 1'b0;
            regtar     <= '0;
            head_pos   <= '0;
            length     <= '0;
            food_eaten <= 1'b0;
        end else begin
            regtar     <= {over, bmap};
            head_pos   <= hd;
            length     <= len;
            food_eaten <= eat;
            eat        <= 1'b0;
            if (dir_valid && (dir_in != (cur_dir ^ 2'd2)))
                pend_dir <= dir_in;
            unique case (state)
                S_IDLE: if (start) state <= S_INIT;
                S_INIT: begin
                    bmap     <= INIT_MAP;
                    over     <= 1'b0;
                    hd       <= 7'd54;
                    len      <= 5'(INIT_LEN);
                    tptr     <= '0;
                    hptr     <= PW'(2);
                    cur_dir  <= 2'd1;
                    pend_dir <= 2'd1;
                    state    <= S_RUN;
                end
                S_RUN: if (tick) state <= S_STEP;
                S_STEP: begin
                    cur_dir <= pend_dir;
                    nh_r    <= nh;
                    hit_r   <= wall || selfh;
                    grow_r  <= grow;
                    eat_r   <= (nh == food_pos);
                    state   <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (hit_r) begin
                        over  <= 1'b1;
                        state <= S_DEAD;
                    end else begin
                        // clear before set so a head landing on the old tail keeps its bit
                        if (!grow_r) begin
                            bmap[tail_cell] <= 1'b0;
                            tptr            <= tptr + P1;
                        end else begin
                            len <= len + 5'd1;
                        end
                        bmap[nh_r] <= 1'b1;
                        hptr       <= hptr + P1;
                        hd         <= nh_r;
                        eat        <= eat_r;
                        state      <= S_RUN;
                    end
                end
                S_DEAD: if (start) state <= S_INIT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
